// File: rtl/rv_pkg.sv
// Shared integer-register-file definitions: default widths, the RV32E register
// count and an x0 detector used by write, scoreboard and read logic.
package rv_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned NREGS_RV32E = 16;

  // Callers zero-extend narrower indices to REG_IDX_W before the call.
  function automatic logic reg_is_zero(input logic [REG_IDX_W-1:0] idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read lane: register select, optional same-cycle write
// bypass and the per-port scoreboard busy flag.
module regfile_rdport
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [NREGS-1:0] busy,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_idx,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mau_we,
  input  logic [AW-1:0]   mau_idx,
  input  logic [XLEN-1:0] mau_data,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_busy
);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (rd_en && !reg_is_zero(REG_IDX_W'(rd_idx))) begin
      rd_data = regs[rd_idx];
      rd_busy = busy[rd_idx];
      if (BYPASS != 0) begin
        // WB is applied last so it overrides MAU on a shared index.
        if (mau_we && mau_idx == rd_idx) begin
          rd_data = mau_data;
          rd_busy = 1'b0;
        end
        if (wb_we && wb_idx == rd_idx) rd_data = wb_data;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port integer register file with a load scoreboard; two write
// ports (WB over MAU) and a sticky write-after-write error flag.
module regfile_sb
  import rv_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_en,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_idx,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                mau_en,
  input  logic [AW-1:0]       mau_idx,
  input  logic [XLEN-1:0]     mau_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_idx,
  input  logic [NRD-1:0]      rs_en,
  input  logic [NRD*AW-1:0]   rs_idx,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  output logic                stall,
  output logic [NREGS-1:0]    busy_vec,
  output logic                waw_err
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wb_we;
  logic             mau_we;
  logic             sb_we;
  logic             waw_hit;

  assign wb_we  = run_en & wb_en & ~reg_is_zero(REG_IDX_W'(wb_idx));
  assign mau_we = mau_en & ~reg_is_zero(REG_IDX_W'(mau_idx));
  assign sb_we  = run_en & sb_set & ~reg_is_zero(REG_IDX_W'(sb_idx));

  // Clear before set so a load issuing to a register whose previous load is
  // returning this cycle stays busy.
  always_comb begin
    busy_nxt = busy;
    if (mau_we) busy_nxt[mau_idx] = 1'b0;
    if (sb_we)  busy_nxt[sb_idx]  = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign waw_hit = (run_en & wb_en  & busy[wb_idx] & ~(mau_en & (mau_idx == wb_idx)))
                 | (run_en & sb_set & busy[sb_idx] & ~(mau_en & (mau_idx == sb_idx)));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      busy    <= '0;
      waw_err <= 1'b0;
    end else begin
      if (mau_we) regs[mau_idx] <= mau_data;
      if (wb_we)  regs[wb_idx]  <= wb_data;
      busy <= busy_nxt;
      if (waw_hit) waw_err <= 1'b1;
    end
  end

  assign busy_vec = busy;
  assign stall    = |rs_busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .BYPASS(BYPASS)
    ) u_rdport (
      .rd_en   (rs_en[p]),
      .rd_idx  (rs_idx[p*AW +: AW]),
      .regs    (regs),
      .busy    (busy),
      .wb_we   (wb_we),
      .wb_idx  (wb_idx),
      .wb_data (wb_data),
      .mau_we  (mau_we),
      .mau_idx (mau_idx),
      .mau_data(mau_data),
      .rd_data (rs_data[p*XLEN +: XLEN]),
      .rd_busy (rs_busy[p])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default instance (32 regs, 2 ports, bypass) and a
// 16-reg, 3-port, no-bypass instance driven in lockstep against a model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset, run_en, wb_en, mau_en, sb_set;
  logic [4:0]  wb_idx, mau_idx, sb_idx;
  logic [31:0] wb_data, mau_data;
  logic [2:0]  rs_en;
  logic [4:0]  ri [3];

  logic [63:0] rd1;  logic [1:0] rb1; logic st1; logic [31:0] bv1; logic we1;
  logic [95:0] rd2;  logic [2:0] rb2; logic st2; logic [15:0] bv2; logic we2;

  // Model state: [0] = default instance, [1] = 16-register instance.
  logic [31:0] m  [2][32];
  logic [31:0] mb [2];
  logic        mw [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb u_dut_a (
    .clk(clk), .reset(reset), .run_en(run_en),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .mau_en(mau_en), .mau_idx(mau_idx), .mau_data(mau_data),
    .sb_set(sb_set), .sb_idx(sb_idx),
    .rs_en(rs_en[1:0]), .rs_idx({ri[1], ri[0]}),
    .rs_data(rd1), .rs_busy(rb1), .stall(st1), .busy_vec(bv1), .waw_err(we1)
  );

  regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset), .run_en(run_en),
    .wb_en(wb_en), .wb_idx(wb_idx[3:0]), .wb_data(wb_data),
    .mau_en(mau_en), .mau_idx(mau_idx[3:0]), .mau_data(mau_data),
    .sb_set(sb_set), .sb_idx(sb_idx[3:0]),
    .rs_en(rs_en), .rs_idx({ri[2][3:0], ri[1][3:0], ri[0][3:0]}),
    .rs_data(rd2), .rs_busy(rb2), .stall(st2), .busy_vec(bv2), .waw_err(we2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int msk(input int k);
    return (k == 0) ? 31 : 15;
  endfunction

  function automatic logic [31:0] exp_data(input int k, input int p);
    int i;
    logic [31:0] v;
    i = ri[p] & msk(k);
    if (!rs_en[p] || i == 0) return 32'h0;
    v = m[k][i];
    if (k == 0) begin
      if (mau_en && (mau_idx & msk(k)) == i) v = mau_data;
      if (run_en && wb_en && (wb_idx & msk(k)) == i) v = wb_data;
    end
    return v;
  endfunction

  function automatic logic exp_busy(input int k, input int p);
    int i;
    i = ri[p] & msk(k);
    if (!rs_en[p] || i == 0) return 1'b0;
    if (k == 0 && mau_en && (mau_idx & msk(k)) == i) return 1'b0;
    return mb[k][i];
  endfunction

  task automatic model_edge(input int k);
    int w, mi, s;
    if (reset) begin
      for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
      mb[k] = 32'h0;
      mw[k] = 1'b0;
      return;
    end
    w  = wb_idx & msk(k);
    mi = mau_idx & msk(k);
    s  = sb_idx & msk(k);
    if (run_en && wb_en && mb[k][w] && !(mau_en && mi == w)) mw[k] = 1'b1;
    if (run_en && sb_set && mb[k][s] && !(mau_en && mi == s)) mw[k] = 1'b1;
    if (mau_en && mi != 0) m[k][mi] = mau_data;
    if (run_en && wb_en && w != 0) m[k][w] = wb_data;
    if (mau_en && mi != 0) mb[k][mi] = 1'b0;
    if (run_en && sb_set && s != 0) mb[k][s] = 1'b1;
  endtask

  // Combinational checks with the current inputs, taken mid low-phase.
  task automatic settle_check();
    logic sa, sb;
    #1;
    sa = 1'b0;
    sb = 1'b0;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("a_data%0d", p), rd1[p*32 +: 32], exp_data(0, p));
      chk($sformatf("a_busy%0d", p), 32'(rb1[p]), 32'(exp_busy(0, p)));
      sa |= exp_busy(0, p);
    end
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("b_data%0d", p), rd2[p*32 +: 32], exp_data(1, p));
      chk($sformatf("b_busy%0d", p), 32'(rb2[p]), 32'(exp_busy(1, p)));
      sb |= exp_busy(1, p);
    end
    chk("a_stall", 32'(st1), 32'(sa));
    chk("b_stall", 32'(st2), 32'(sb));
  endtask

  task automatic edge_check();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    chk("a_busy_vec", bv1, mb[0]);
    chk("b_busy_vec", 32'(bv2), mb[1] & 32'hFFFF);
    chk("a_waw", 32'(we1), 32'(mw[0]));
    chk("b_waw", 32'(we2), 32'(mw[1]));
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    edge_check();
  endtask

  task automatic idle();
    reset = 1'b0; run_en = 1'b1; wb_en = 1'b0; mau_en = 1'b0; sb_set = 1'b0;
    wb_idx = '0; mau_idx = '0; sb_idx = '0; wb_data = '0; mau_data = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    edge_check();
    reset = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m[k][i] = 32'h0;
      mb[k] = 32'h0;
      mw[k] = 1'b0;
    end
    rs_en = '0;
    for (int p = 0; p < 3; p++) ri[p] = '0;
    idle();
    @(negedge clk);
    do_reset();

    // Reset contents, then x0 write attempts through both ports.
    rs_en = 3'b111;
    for (int i = 1; i < 32; i += 3) begin
      for (int p = 0; p < 3; p++) ri[p] = 5'((i + p) % 32);
      step();
    end
    wb_en = 1'b1; wb_idx = 5'd0; wb_data = 32'hFFFF_FFFF;
    mau_en = 1'b1; mau_idx = 5'd0; mau_data = 32'hFFFF_FFFF;
    step();
    idle();
    ri[0] = 5'd0;
    settle_check();
    chk("x0_reads_zero", rd1[31:0], 32'h0);
    edge_check();

    // WB beats MAU on the same index; busy clears.
    sb_set = 1'b1; sb_idx = 5'd5;
    step();
    idle();
    wb_en = 1'b1; wb_idx = 5'd5; wb_data = 32'hDEAD_BEEF;
    mau_en = 1'b1; mau_idx = 5'd5; mau_data = 32'h1234_5678;
    step();
    idle();
    ri[0] = 5'd5;
    settle_check();
    chk("wb_wins_a", rd1[31:0], 32'hDEAD_BEEF);
    chk("wb_wins_b", rd2[31:0], 32'hDEAD_BEEF);
    chk("x5_busy_clear", 32'(bv1[5]), 32'h0);
    edge_check();

    // Busy register read, with and without a returning load.
    sb_set = 1'b1; sb_idx = 5'd7;
    step();
    idle();
    ri[0] = 5'd7;
    settle_check();
    chk("x7_busy", 32'(rb1[0]), 32'h1);
    chk("x7_stall", 32'(st1), 32'h1);
    edge_check();
    mau_en = 1'b1; mau_idx = 5'd7; mau_data = 32'hA5A5_A5A5;
    settle_check();
    chk("x7_bypass_data", rd1[31:0], 32'hA5A5_A5A5);
    chk("x7_bypass_busy", 32'(rb1[0]), 32'h0);
    chk("x7_nobypass_busy", 32'(rb2[0]), 32'h1);
    edge_check();
    idle();
    settle_check();
    chk("x7_busy_after", 32'(rb2[0]), 32'h0);
    chk("x7_stored", rd2[31:0], 32'hA5A5_A5A5);
    edge_check();

    // WB to a busy register raises sticky waw_err.
    sb_set = 1'b1; sb_idx = 5'd9;
    step();
    idle();
    wb_en = 1'b1; wb_idx = 5'd9; wb_data = 32'hCAFE_F00D;
    step();
    idle();
    chk("waw_set", 32'(we1), 32'h1);
    for (int i = 0; i < 10; i++) step();
    chk("waw_hold", 32'(we1), 32'h1);
    ri[0] = 5'd9;
    settle_check();
    chk("x9_written", rd1[31:0], 32'hCAFE_F00D);
    edge_check();
    do_reset();
    chk("waw_reset", 32'(we1), 32'h0);

    // Re-issue to a register whose load returns the same cycle.
    sb_set = 1'b1; sb_idx = 5'd3;
    step();
    idle();
    sb_set = 1'b1; sb_idx = 5'd3;
    mau_en = 1'b1; mau_idx = 5'd3; mau_data = 32'h0000_0333;
    step();
    idle();
    chk("x3_still_busy", 32'(bv1[3]), 32'h1);
    chk("x3_no_waw", 32'(we1), 32'h0);

    // run_en low blocks WB and scoreboard set; reset clears busy.
    run_en = 1'b0;
    wb_en = 1'b1; wb_idx = 5'd4; wb_data = 32'h4444_4444;
    sb_set = 1'b1; sb_idx = 5'd11;
    ri[0] = 5'd4; ri[1] = 5'd11;
    step();
    idle();
    chk("x11_not_busy", 32'(bv1[11]), 32'h0);
    settle_check();
    chk("x4_unchanged", rd1[31:0], 32'h0);
    edge_check();
    do_reset();
    chk("busy_reset_a", bv1, 32'h0);
    chk("busy_reset_b", 32'(bv2), 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      run_en   = ($urandom_range(0, 7) != 0);
      wb_en    = $urandom_range(0, 1) == 1;
      mau_en   = $urandom_range(0, 2) == 0;
      sb_set   = $urandom_range(0, 2) == 0;
      wb_idx   = 5'($urandom);
      mau_idx  = 5'($urandom);
      sb_idx   = 5'($urandom);
      wb_data  = $urandom;
      mau_data = $urandom;
      rs_en    = 3'($urandom);
      for (int p = 0; p < 3; p++) begin
        ri[p] = ($urandom_range(0, 3) == 0) ? wb_idx :
                ($urandom_range(0, 2) == 0) ? mau_idx : 5'($urandom);
      end
      step();
      if (n == 200) begin
        rs_en = '0;
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
